ntt_seq_ctrl: RTL and testbench

//  Command-level sequencer for the shared NTT/INTT address generator and butterfly datapath.

---
 rtl/ntt_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ntt_seq_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_seq_ctrl.sv
// Command sequencer for the shared NTT/INTT address generator and butterfly.
// Holds mode stable per job, delays read controls into write-back, drains, responds.
module ntt_seq_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int ZETA_W  = 7,
  parameter int BF_LAT  = 4,
  parameter int TMO_W   = 11,
  parameter int MAX_CYC = 1100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic              abort,
  output logic              ag_sel,
  output logic              ag_start,
  output logic              ag_clr,
  input  logic [ADDR_W-1:0] ag_addr_up,
  input  logic [ADDR_W-1:0] ag_addr_dn,
  input  logic [ZETA_W-1:0] ag_zeta,
  input  logic              ag_active,
  input  logic              ag_last,
  input  logic              ag_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_up,
  output logic [ADDR_W-1:0] rd_addr_dn,
  output logic [ZETA_W-1:0] zeta_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_up,
  output logic [ADDR_W-1:0] wr_addr_dn,
  output logic              wr_scale,
  output logic              busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_RESP
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MAX_CYC - 1);
  localparam logic [TMO_W-1:0] DRN_LAST = TMO_W'(BF_LAT - 1);

  state_e state_q, state_d;

  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             clr_q, clr_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic [BF_LAT-1:0]             vld_q, vld_d;
  logic [BF_LAT-1:0]             sc_q, sc_d;
  logic [BF_LAT-1:0][ADDR_W-1:0] up_q, up_d;
  logic [BF_LAT-1:0][ADDR_W-1:0] dn_q, dn_d;

  logic kill;
  logic tmo;
  logic drn_end;

  // abort only acts on an active job; it outranks done and timeout
  assign kill = abort & (state_q != S_IDLE) & (state_q != S_RESP);
  assign tmo = (state_q == S_RUN) & ~ag_done & (cnt_q == TMO_LAST);
  assign drn_end = (state_q == S_DRAIN) & (cnt_q == DRN_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_SETTLE;
      S_SETTLE: state_d = S_START;
      S_START:  state_d = S_RUN;
      S_RUN:    if (ag_done | tmo) state_d = S_DRAIN;
      S_DRAIN:  if (drn_end) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (kill) state_d = S_RESP;
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    ag_start  = 1'b0;
    rd_en     = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_START: ag_start = 1'b1;
      S_RUN:   rd_en = ag_active;
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    if (cmd_ready & cmd_valid) mode_d = cmd_mode;
    err_d = err_q;
    if (kill | tmo) begin
      err_d = 1'b1;
    end else if (rsp_valid & rsp_ready) begin
      err_d = 1'b0;
    end
    clr_d = kill | tmo;
    cnt_d = cnt_q;
    unique case (state_q)
      S_START: cnt_d = '0;
      S_RUN:   cnt_d = (ag_done | tmo) ? '0 : cnt_q + TMO_W'(1);
      S_DRAIN: cnt_d = cnt_q + TMO_W'(1);
      default: ;
    endcase
  end

  // write-back delay line; shifts every cycle, flushed on abort
  always_comb begin
    vld_d    = vld_q;
    sc_d     = sc_q;
    up_d     = up_q;
    dn_d     = dn_q;
    vld_d[0] = rd_en;
    sc_d[0]  = rd_en & ag_last & mode_q;
    up_d[0]  = ag_addr_up;
    dn_d[0]  = ag_addr_dn;
    for (int i = 1; i < BF_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      sc_d[i]  = sc_q[i-1];
      up_d[i]  = up_q[i-1];
      dn_d[i]  = dn_q[i-1];
    end
    if (kill) begin
      vld_d = '0;
      sc_d  = '0;
      up_d  = '0;
      dn_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      err_q  <= 1'b0;
      clr_q  <= 1'b0;
      cnt_q  <= '0;
      vld_q  <= '0;
      sc_q   <= '0;
      up_q   <= '0;
      dn_q   <= '0;
    end else begin
      mode_q <= mode_d;
      err_q  <= err_d;
      clr_q  <= clr_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      sc_q   <= sc_d;
      up_q   <= up_d;
      dn_q   <= dn_d;
    end
  end

  assign ag_sel     = mode_q;
  assign ag_clr     = clr_q;
  assign rd_addr_up = ag_addr_up;
  assign rd_addr_dn = ag_addr_dn;
  assign zeta_idx   = ag_zeta;
  assign wr_en      = vld_q[BF_LAT-1];
  assign wr_scale   = sc_q[BF_LAT-1];
  assign wr_addr_up = up_q[BF_LAT-1];
  assign wr_addr_dn = dn_q[BF_LAT-1];

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Bench for ntt_seq_ctrl: table of job scenarios plus random jobs,
// checked against an event/queue model of the job-level behaviour.
module tb_ntt_seq_ctrl;

  localparam int ADDR_W  = 8;
  localparam int ZETA_W  = 7;
  localparam int BF_LAT  = 4;
  localparam int TMO_W   = 11;
  localparam int MAX_CYC = 1100;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_mode, abort;
  logic              ag_sel, ag_start, ag_clr;
  logic [ADDR_W-1:0] ag_addr_up, ag_addr_dn;
  logic [ZETA_W-1:0] ag_zeta;
  logic              ag_active, ag_last, ag_done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_up, rd_addr_dn;
  logic [ZETA_W-1:0] zeta_idx;
  logic              wr_en, wr_scale;
  logic [ADDR_W-1:0] wr_addr_up, wr_addr_dn;
  logic              busy, rsp_valid, rsp_ready, rsp_err;

  ntt_seq_ctrl #(
    .ADDR_W (ADDR_W),
    .ZETA_W (ZETA_W),
    .BF_LAT (BF_LAT),
    .TMO_W  (TMO_W),
    .MAX_CYC(MAX_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .abort     (abort),
    .ag_sel    (ag_sel),
    .ag_start  (ag_start),
    .ag_clr    (ag_clr),
    .ag_addr_up(ag_addr_up),
    .ag_addr_dn(ag_addr_dn),
    .ag_zeta   (ag_zeta),
    .ag_active (ag_active),
    .ag_last   (ag_last),
    .ag_done   (ag_done),
    .rd_en     (rd_en),
    .rd_addr_up(rd_addr_up),
    .rd_addr_dn(rd_addr_dn),
    .zeta_idx  (zeta_idx),
    .wr_en     (wr_en),
    .wr_addr_up(wr_addr_up),
    .wr_addr_dn(wr_addr_dn),
    .wr_scale  (wr_scale),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       rel;
    logic [ADDR_W-1:0] up;
    logic [ADDR_W-1:0] dn;
    logic              sc;
  } rec_t;

  typedef struct {
    bit mode;
    int n_act;
    int n_last;
    bit gaps;
    bit no_done;
    int abort_at;
    int rsp_hold;
    bit hold_valid;
    int exp_err;
    int exp_wr;
    int exp_sc;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    cmd_valid  = 1'b0;
    cmd_mode   = 1'b0;
    abort      = 1'b0;
    ag_addr_up = '0;
    ag_addr_dn = '0;
    ag_zeta    = '0;
    ag_active  = 1'b0;
    ag_last    = 1'b0;
    ag_done    = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_cmd_ready"}, cmd_ready, 1);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_ag_sel"}, ag_sel, 0);
    chk({p, "_ag_start"}, ag_start, 0);
    chk({p, "_ag_clr"}, ag_clr, 0);
    chk({p, "_rd_en"}, rd_en, 0);
    chk({p, "_wr_en"}, wr_en, 0);
    chk({p, "_wr_addr_up"}, wr_addr_up, 0);
    chk({p, "_wr_addr_dn"}, wr_addr_dn, 0);
    chk({p, "_wr_scale"}, wr_scale, 0);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_err"}, rsp_err, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_job(input string nm, input vec_t v);
    rec_t rd_q[$];
    rec_t wr_q[$];
    rec_t x;
    int   start_rel = -1, nstart = 0, clr_rel = -1, nclr = 0;
    int   resp_rel = -1, exp_resp = -1, exp_clr = -1;
    int   cut = 1 << 30;
    int   k = 0, seen_rv = 0, nsc = 0, ew = 0;
    int   e_rd = 0, e_pass = 0, e_sel = 0, e_rdy = 0, e_busy = 0;
    int   e_rv = 0, e_err = 0, e_wr = 0;
    bit   ag_run = 0, ag_stop = 0, done_hs = 0, exp_err_m = 0, rdy0 = 0;
    logic last_err = 1'b0;
    logic d_act, d_done, d_last;
    logic [ADDR_W-1:0] d_up, d_dn;
    logic [ZETA_W-1:0] d_z;
    for (int rel = 0; rel < 3000 && !done_hs; rel++) begin
      @(posedge clk);
      #1;
      cmd_valid = (rel == 0) || v.hold_valid;
      cmd_mode  = v.mode;
      abort     = (rel == v.abort_at);
      d_act = 0; d_done = 0; d_last = 0;
      d_up = '0; d_dn = '0; d_z = '0;
      if (ag_run && !ag_stop && k < v.n_act &&
          !(v.gaps && $urandom_range(0, 3) == 0)) begin
        d_act  = 1'b1;
        d_up   = ADDR_W'($urandom);
        d_dn   = ADDR_W'($urandom);
        d_z    = ZETA_W'($urandom);
        d_last = (k >= v.n_act - v.n_last);
        d_done = (k == v.n_act - 1) && !v.no_done;
        k++;
      end
      ag_active  = d_act;
      ag_done    = d_done;
      ag_last    = d_last;
      ag_addr_up = d_up;
      ag_addr_dn = d_dn;
      ag_zeta    = d_z;
      rsp_ready  = (seen_rv >= v.rsp_hold);
      if (d_done && exp_resp < 0) exp_resp = rel + BF_LAT + 1;
      if (abort && rel >= 1 && (exp_resp < 0 || rel < exp_resp)) begin
        exp_resp  = rel + 1;
        exp_clr   = rel + 1;
        cut       = rel;
        exp_err_m = 1;
      end
      if (exp_resp < 0 && rel == 2 + MAX_CYC) begin
        exp_clr   = rel + 1;
        exp_resp  = rel + 1 + BF_LAT;
        exp_err_m = 1;
      end
      if (abort && rel >= 1) ag_stop = 1;
      @(negedge clk);
      if (rel == 0) rdy0 = cmd_ready;
      if (ag_start) begin
        nstart++;
        start_rel = rel;
        if (!ag_stop) ag_run = 1;
      end
      if (ag_clr) begin
        nclr++;
        clr_rel = rel;
        ag_stop = 1;
      end
      if (rel >= 1 && cmd_ready !== 1'b0) e_rdy++;
      if (rel >= 1 && busy !== 1'b1) e_busy++;
      if (rel >= 1 && ag_sel !== v.mode) e_sel++;
      if (rd_en !== d_act) e_rd++;
      if (rd_addr_up !== d_up || rd_addr_dn !== d_dn || zeta_idx !== d_z)
        e_pass++;
      if (d_act) rd_q.push_back('{rel, d_up, d_dn, d_last & v.mode});
      if (wr_en) begin
        wr_q.push_back('{rel, wr_addr_up, wr_addr_dn, wr_scale});
        if (wr_scale) nsc++;
      end
      if (rsp_valid !== (exp_resp >= 0 && rel >= exp_resp)) e_rv++;
      if (rsp_valid) begin
        if (resp_rel < 0) resp_rel = rel;
        if (rsp_err !== exp_err_m) e_err++;
        last_err = rsp_err;
        if (rsp_ready) done_hs = 1;
        seen_rv++;
      end
    end
    chk({nm, "_finished"}, done_hs, 1);
    chk({nm, "_cmd_ready_idle"}, rdy0, 1);
    chk({nm, "_ag_start_cnt"}, nstart, (v.abort_at == 1) ? 0 : 1);
    if (nstart > 0) chk({nm, "_ag_start_rel"}, start_rel, 2);
    chk({nm, "_ag_clr_cnt"}, nclr, (exp_clr >= 0) ? 1 : 0);
    if (exp_clr >= 0) chk({nm, "_ag_clr_rel"}, clr_rel, exp_clr);
    chk({nm, "_rsp_rel"}, resp_rel, exp_resp);
    chk({nm, "_rsp_valid_errs"}, e_rv, 0);
    chk({nm, "_rsp_err_errs"}, e_err, 0);
    chk({nm, "_rd_en_errs"}, e_rd, 0);
    chk({nm, "_pass_errs"}, e_pass, 0);
    chk({nm, "_ag_sel_errs"}, e_sel, 0);
    chk({nm, "_cmd_ready_busy_errs"}, e_rdy, 0);
    chk({nm, "_busy_errs"}, e_busy, 0);
    foreach (rd_q[i]) begin
      if (rd_q[i].rel + BF_LAT <= cut) begin
        x = rd_q[i];
        x.rel = x.rel + BF_LAT;
        if (ew >= wr_q.size() || wr_q[ew] !== x) e_wr++;
        ew++;
      end
    end
    chk({nm, "_wr_cnt"}, wr_q.size(), ew);
    chk({nm, "_wr_seq_errs"}, e_wr, 0);
    if (v.exp_wr >= 0) chk({nm, "_wr_cnt_tbl"}, wr_q.size(), v.exp_wr);
    if (v.exp_sc >= 0) chk({nm, "_scale_tbl"}, nsc, v.exp_sc);
    if (v.exp_err >= 0) chk({nm, "_err_tbl"}, last_err, v.exp_err);
    if (!done_hs) do_reset();
  endtask

  task automatic rst_mid_run();
    int nw = 0;
    int e = 0;
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk);
      #1;
      cmd_valid  = (c == 0);
      cmd_mode   = 1'b1;
      ag_active  = (c >= 3);
      ag_addr_up = ADDR_W'($urandom);
      ag_addr_dn = ADDR_W'($urandom);
      ag_last    = 1'b1;
      rsp_ready  = 1'b1;
      rst        = (c == 10);
      abort      = (c == 10);
      ag_done    = (c == 10);
      @(negedge clk);
      if (wr_en) nw++;
    end
    chk("rst_pre_writes", nw > 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    chk_idle("rst_mid");
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (wr_en !== 1'b0 || busy !== 1'b0) e++;
    end
    chk("rst_quiet_errs", e, 0);
  endtask

  initial begin
    vec_t tbl[11];
    vec_t rv;
    tbl[0]  = '{0, 896,   0, 0, 0, -1, 0, 0, 0, 896,   0};
    tbl[1]  = '{1, 896, 128, 0, 0, -1, 1, 0, 0, 896, 128};
    tbl[2]  = '{0, 896,   0, 0, 0, 13, 0, 0, 1,   7,   0};
    tbl[3]  = '{0,  40,   0, 1, 0, -1, 0, 0, 0,  40,   0};
    tbl[4]  = '{0,  50,   0, 0, 1, -1, 0, 0, 1,  50,   0};
    tbl[5]  = '{1,  20,   5, 0, 0, -1, 5, 1, 0,  20,   5};
    tbl[6]  = '{0,  10,   0, 0, 0, 14, 0, 0, 1,   8,   0};
    tbl[7]  = '{1,  10,  10, 0, 0,  1, 0, 0, 1,   0,   0};
    tbl[8]  = '{0,  10,   0, 0, 0,  0, 2, 0, 0,  10,   0};
    tbl[9]  = '{0,  10,   0, 0, 0,  2, 0, 0, 1,   0,   0};
    tbl[10] = '{0,  10,   0, 0, 0, 12, 0, 0, 1,   6,   0};
    drive_idle();
    rst = 1'b1;
    do_reset();
    for (int i = 0; i < 11; i++) run_job($sformatf("tbl%0d", i), tbl[i]);
    rst_mid_run();
    for (int i = 0; i < 12; i++) begin
      rv.mode       = 1'($urandom_range(0, 1));
      rv.n_act      = $urandom_range(5, 150);
      rv.n_last     = $urandom_range(0, rv.n_act);
      rv.gaps       = 1;
      rv.no_done    = 0;
      rv.abort_at   = ($urandom_range(0, 2) == 0) ?
                      $urandom_range(0, rv.n_act + 12) : -1;
      rv.rsp_hold   = $urandom_range(0, 3);
      rv.hold_valid = 1'($urandom_range(0, 1));
      rv.exp_err    = -1;
      rv.exp_wr     = -1;
      rv.exp_sc     = -1;
      run_job($sformatf("rnd%0d", i), rv);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
